// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter with a bounded grant length.
// Grants last until the owner releases, the request drops, enable falls, or HOLD_MAX is reached.
module rr_arbiter #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic       valid,
   output logic       timeout
);

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_nx;
   logic [1:0] ptr, ptr_nx;
   logic [3:0] hold_cnt, hold_cnt_nx;
   logic [3:0] grant_nx;
   logic [1:0] grant_id_nx;
   logic       valid_nx;
   logic       timeout_nx;

   logic       found;
   logic [1:0] pick_id;
   logic [1:0] idx;
   logic       release_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 2'd0;
         hold_cnt <= 4'd0;
         grant    <= 4'd0;
         grant_id <= 2'd0;
         valid    <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         hold_cnt <= hold_cnt_nx;
         grant    <= grant_nx;
         grant_id <= grant_id_nx;
         valid    <= valid_nx;
         timeout  <= timeout_nx;
      end
   end

   // First set request at or above ptr, wrapping modulo 4.
   always_comb begin
      found   = 1'b0;
      pick_id = ptr;
      idx     = ptr;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            found   = 1'b1;
            pick_id = idx;
         end
      end
   end

   assign release_req = done || !req[grant_id] || !enable;

   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      hold_cnt_nx = hold_cnt;
      grant_nx    = grant;
      grant_id_nx = grant_id;
      valid_nx    = valid;
      timeout_nx  = 1'b0;
      case (state)
         IDLE: begin
            grant_nx = 4'd0;
            valid_nx = 1'b0;
            if (enable && found) begin
               state_nx    = GRANT;
               grant_nx    = 4'b0001 << pick_id;
               grant_id_nx = pick_id;
               valid_nx    = 1'b1;
               hold_cnt_nx = 4'd0;
            end
         end
         GRANT: begin
            // An owner-side release wins over the hold limit, so timeout stays low then.
            if (release_req || hold_cnt == HOLD_LAST) begin
               state_nx   = IDLE;
               grant_nx   = 4'd0;
               valid_nx   = 1'b0;
               ptr_nx     = grant_id + 2'd1;
               timeout_nx = !release_req;
            end else begin
               hold_cnt_nx = hold_cnt + 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter with hand-computed expectations (HOLD_MAX = 8).
module tb_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   rr_arbiter #(.HOLD_MAX(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .req      (req),
      .done     (done),
      .grant    (grant),
      .grant_id (grant_id),
      .valid    (valid),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic v, input logic t);
      check({tag, ".grant"}, grant, g);
      check({tag, ".grant_id"}, {2'b00, grant_id}, {2'b00, id});
      check({tag, ".valid"}, {3'b000, valid}, {3'b000, v});
      check({tag, ".timeout"}, {3'b000, timeout}, {3'b000, t});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Structural invariants sampled on the falling edge.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         check("inv.onehot", {3'b000, $onehot0(grant)}, 4'd1);
         check("inv.valid", {3'b000, valid}, {3'b000, grant != 4'd0});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] seq [5];
      logic [1:0] seq_id [5];
      seq    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      seq_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      rst = 1'b1; enable = 1'b0; req = 4'd0; done = 1'b0;
      #2;
      check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      repeat (2) tick();
      rst = 1'b0;

      // Basic grant and pointer advance.
      enable = 1'b1; req = 4'b0110;
      tick(); check_all("basic.g1", 4'b0010, 2'd1, 1'b1, 1'b0);
      done = 1'b1;
      tick(); check_all("basic.rel", 4'b0000, 2'd1, 1'b0, 1'b0);
      done = 1'b0;
      tick(); check_all("basic.g2", 4'b0100, 2'd2, 1'b1, 1'b0);
      req = 4'b0000;
      tick(); check_all("basic.drop", 4'b0000, 2'd2, 1'b0, 1'b0);
      tick();

      // Async reset between edges restores ptr=0.
      #2 rst = 1'b1;
      #2 rst = 1'b0;

      // Round-robin wrap with full request.
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         done = 1'b0;
         tick(); check_all($sformatf("rr.g%0d", k), seq[k], seq_id[k], 1'b1, 1'b0);
         done = 1'b1;
         tick(); check_all($sformatf("rr.gap%0d", k), 4'b0000, seq_id[k], 1'b0, 1'b0);
      end
      done = 1'b0;

      // Timeout after 8 cycles, one idle cycle, then regrant.
      req = 4'b0001;
      tick(); check_all("to.c1", 4'b0001, 2'd0, 1'b1, 1'b0);
      for (int k = 2; k <= 8; k++) begin
         tick(); check_all($sformatf("to.c%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      tick(); check_all("to.pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
      tick(); check_all("to.regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

      // done coincides with the hold limit: no timeout.
      repeat (7) tick();
      check_all("sim.held", 4'b0001, 2'd0, 1'b1, 1'b0);
      done = 1'b1;
      tick(); check_all("sim.done_at_max", 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;
      tick(); check_all("sim.regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = 4'b0010;
      tick(); check_all("sim.req_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
      tick(); check_all("sim.next", 4'b0010, 2'd1, 1'b1, 1'b0);

      // Enable gating.
      enable = 1'b0; req = 4'b1111;
      tick(); check_all("en.drop", 4'b0000, 2'd1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick(); check_all($sformatf("en.off%0d", k), 4'b0000, 2'd1, 1'b0, 1'b0);
      end
      enable = 1'b1;
      tick(); check_all("en.on", 4'b0100, 2'd2, 1'b1, 1'b0);

      // Async reset mid-grant drops the grant before the next edge.
      #3 rst = 1'b1;
      #1 check_all("areset.mid", 4'b0000, 2'd0, 1'b0, 1'b0);
      req = 4'b1010;
      #2 rst = 1'b0;
      tick(); check_all("areset.after", 4'b0010, 2'd1, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum grant length in clock cycles; legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  arbitration enable; high permits new grants.
REQ-005 req  input  4  request lines; bit i is requester i.
REQ-006 done  input  1  current owner releases the resource.
REQ-007 grant  output  4  registered one-hot grant; all zeros when no requester owns the resource.
REQ-008 grant_id  output  2  binary encoding of grant: 0001->00, 0010->01, 0100->10, 1000->11.
REQ-009 valid  output  1  high exactly when grant is non-zero.
REQ-010 timeout  output  1  one-cycle pulse when a grant is force-released at HOLD_MAX.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 In IDLE with enable=1 and req!=0, the block SHALL select the first set req bit searching upward from ptr, modulo 4.
REQ-013 On the same edge as REQ-012, it SHALL register grant, grant_id and valid=1, clear hold_cnt to 0, and enter GRANT; grant latency from req is 1 cycle.
REQ-014 In IDLE with enable=0 or req=0, the block SHALL stay in IDLE with grant=0000, valid=0 and grant_id held at its last value.
REQ-015 In GRANT, hold_cnt (4 bits) SHALL increment on every cycle in which no release occurs.
REQ-016 In GRANT, release SHALL occur on the edge where done=1, req[grant_id]=0, or enable=0; the block then enters IDLE, grant=0000, valid=0, and timeout=0.
REQ-017 In GRANT, if hold_cnt==HOLD_MAX-1 and no REQ-016 condition holds, the block SHALL force-release to IDLE and pulse timeout=1 for one cycle.
REQ-018 When a REQ-016 condition and the HOLD_MAX limit coincide, REQ-016 SHALL take precedence and timeout SHALL stay 0.
REQ-019 On every release, ptr SHALL update to grant_id+1 modulo 4, wrapping 3 to 0.
REQ-020 Every release SHALL be followed by at least one IDLE cycle with grant=0000 (no back-to-back grants), so the maximum grant length is HOLD_MAX cycles.
REQ-021 grant SHALL never have more than one bit set.
REQ-022 grant_id SHALL always equal the encoding of grant whenever valid=1.
REQ-023 Changes on req or done in IDLE other than those in REQ-012 SHALL have no effect.

Reset
REQ-024 Assertion of rst SHALL immediately, without waiting for clk, force: state=IDLE, grant=0000, grant_id=00, valid=0, timeout=0, ptr=0, hold_cnt=0.
REQ-025 A reset asserted during GRANT SHALL drop the grant at once, with no timeout pulse.
REQ-026 After rst deasserts, the first grant SHALL be computed from ptr=0, so req[0] has highest priority.

Verification
REQ-027 Basic grant: reset, enable=1, req=0110 -> next edge grant=0010, grant_id=01, valid=1; done pulse -> grant=0000 for one cycle, then grant=0100, grant_id=10.
REQ-028 Round-robin wrap: req=1111 held with a done pulse in each grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with a single zero-grant cycle between grants.
REQ-029 Timeout: HOLD_MAX=8, req=0001 held, done=0 -> grant high for exactly 8 cycles, timeout=1 on the release edge, then 1 idle cycle, then regrant to 0001.
REQ-030 Simultaneous events: done=1 on the cycle where hold_cnt=HOLD_MAX-1 -> release with timeout=0; a requester dropping its req mid-grant -> release on the next edge.
REQ-031 Enable gating: enable=0 with req=1111 -> grant stays 0000; deasserting enable mid-grant -> release on the next edge, timeout=0.
REQ-032 Async reset: assert rst between clock edges during GRANT -> grant=0000 and valid=0 before the next edge; after release of rst with req=1010 -> grant=0010.
